// File: rtl/eco32f_rf_write_sched.sv
// Register-file write-port scheduler: merges in-order writeback with buffered
// long-latency results, tracks pending destinations, and forces drain slots.
module eco32f_rf_write_sched #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  output logic        pipe_hold,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  logic [4:0]  fifo_addr_reg [2];
  logic [31:0] fifo_data_reg [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg, count_next;

  logic [31:0] pending_reg, pending_next;
  logic [31:0] set_vec, clr_vec;

  logic [3:0]  starve_reg, starve_next;
  logic        pipe_hold_reg, pipe_hold_next;

  logic        rf_we_reg, rf_we_next;
  logic [4:0]  rf_waddr_reg, rf_waddr_next;
  logic [31:0] rf_wdata_reg, rf_wdata_next;

  logic        fifo_full, fifo_empty, enq, grant_fifo;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [3:0]  starve_inc;

  assign fifo_full  = (count_reg == 2'd2);
  assign fifo_empty = (count_reg == 2'd0);
  assign lu_ready   = !fifo_full;
  // A result arriving while full is dropped, so enqueue is gated by ready.
  assign enq        = lu_valid && !fifo_full;
  assign grant_fifo = !pipe_we && !fifo_empty;
  assign head_addr  = fifo_addr_reg[rd_ptr_reg];
  assign head_data  = fifo_data_reg[rd_ptr_reg];
  assign starve_inc = starve_reg + 4'd1;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      assign set_vec[gi] = (gi != 0) && lu_issue && (lu_issue_addr == gi[4:0]);
      assign clr_vec[gi] = grant_fifo && (head_addr == gi[4:0]);
    end
  endgenerate

  // Clear first, then set, so an issue racing a drain of the same register wins.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  assign hazard = ((rs_addr != 5'd0) && pending_reg[rs_addr]) ||
                  ((rt_addr != 5'd0) && pending_reg[rt_addr]) ||
                  ((rd_addr != 5'd0) && pending_reg[rd_addr]);

  always_comb begin
    count_next = count_reg;
    case ({enq, grant_fifo})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    starve_next    = 4'd0;
    pipe_hold_next = 1'b0;
    if (!fifo_empty && pipe_we) begin
      if (starve_inc == STARVE_MAX[3:0]) begin
        pipe_hold_next = 1'b1;
      end else begin
        starve_next = starve_inc;
      end
    end
  end

  always_comb begin
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (pipe_we) begin
      rf_we_next    = (pipe_addr != 5'd0);
      rf_waddr_next = pipe_addr;
      rf_wdata_next = pipe_data;
    end else if (grant_fifo) begin
      rf_we_next    = (head_addr != 5'd0);
      rf_waddr_next = head_addr;
      rf_wdata_next = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_reg[wr_ptr_reg] <= lu_addr;
      fifo_data_reg[wr_ptr_reg] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      pending_reg   <= 32'd0;
      starve_reg    <= 4'd0;
      pipe_hold_reg <= 1'b0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= 5'd0;
      rf_wdata_reg  <= 32'd0;
    end else begin
      if (enq)        wr_ptr_reg <= !wr_ptr_reg;
      if (grant_fifo) rd_ptr_reg <= !rd_ptr_reg;
      count_reg     <= count_next;
      pending_reg   <= pending_next;
      starve_reg    <= starve_next;
      pipe_hold_reg <= pipe_hold_next;
      rf_we_reg     <= rf_we_next;
      rf_waddr_reg  <= rf_waddr_next;
      rf_wdata_reg  <= rf_wdata_next;
    end
  end

  assign pipe_hold = pipe_hold_reg;
  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;

endmodule

// File: tb/tb_eco32f_rf_write_sched.sv
// Directed bench for eco32f_rf_write_sched: pipe writes, late results,
// collisions, starvation hold, scoreboard race and async reset.
`timescale 1ns/1ps
module tb_eco32f_rf_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_hold;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eco32f_rf_write_sched #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_hold(pipe_hold),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1ns later, inputs changed there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we; pipe_addr = a; pipe_data = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_addr = a; lu_data = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0); lu(0, 0, 0);
    lu_issue = 0; lu_issue_addr = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_waddr", {27'd0, rf_waddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_hold", {31'd0, pipe_hold}, 0);
    chk("rst_ready", {31'd0, lu_ready}, 1);
    step(); step();
    rst = 1'b0;

    // Pipe-only writes, including suppression of r0
    pipe(1, 5, 32'h12345678); step();
    chk("pipe_we", {31'd0, rf_we}, 1);
    chk("pipe_addr", {27'd0, rf_waddr}, 5);
    chk("pipe_data", rf_wdata, 32'h12345678);
    pipe(1, 0, 32'h55); step();
    chk("pipe_r0_we", {31'd0, rf_we}, 0);
    pipe(0, 0, 0); step();
    chk("idle_we", {31'd0, rf_we}, 0);

    // Late result: issue r7, hazard until the write lands
    lu_issue = 1; lu_issue_addr = 7; step();
    lu_issue = 0; rs_addr = 7; #1;
    chk("haz_rs7", {31'd0, hazard}, 1);
    lu(1, 7, 32'hDEADBEEF); step();
    lu(0, 0, 0); #1;
    chk("late_nobypass", {31'd0, rf_we}, 0);
    chk("late_haz_hold", {31'd0, hazard}, 1);
    step();
    chk("late_we", {31'd0, rf_we}, 1);
    chk("late_addr", {27'd0, rf_waddr}, 7);
    chk("late_data", rf_wdata, 32'hDEADBEEF);
    chk("late_haz_clr", {31'd0, hazard}, 0);
    rs_addr = 0;

    // Issue to r0 never marks pending
    lu_issue = 1; lu_issue_addr = 0; step();
    lu_issue = 0; rd_addr = 0; #1;
    chk("haz_r0", {31'd0, hazard}, 0);

    // Collision: pipe r3 first, FIFO r9 next
    pipe(1, 3, 32'h33); lu(1, 9, 32'h99); step();
    chk("coll_pipe", {27'd0, rf_waddr}, 3);
    pipe(0, 0, 0); lu(0, 0, 0); step();
    chk("coll_fifo", {27'd0, rf_waddr}, 9);
    chk("coll_fdata", rf_wdata, 32'h99);

    // Fill FIFO under pipe traffic, attempt a third enqueue (dropped)
    pipe(1, 1, 32'h11); lu(1, 10, 32'hA); step();
    chk("fill1_ready", {31'd0, lu_ready}, 1);
    lu(1, 11, 32'hB); step();
    chk("fill2_ready", {31'd0, lu_ready}, 0);
    lu(1, 12, 32'hC); step();
    chk("full_ready", {31'd0, lu_ready}, 0);
    pipe(0, 0, 0); lu(0, 0, 0); step();
    chk("drain1_addr", {27'd0, rf_waddr}, 10);
    chk("drain1_ready", {31'd0, lu_ready}, 1);
    step();
    chk("drain2_addr", {27'd0, rf_waddr}, 11);
    chk("drain2_data", rf_wdata, 32'hB);
    step();
    chk("drop_idle", {31'd0, rf_we}, 0);

    // Starvation: one FIFO entry, pipe busy
    pipe(1, 2, 32'h20); lu(1, 13, 32'h13); step();
    lu(0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("starve_c%0d", i), {31'd0, pipe_hold}, 0);
    end
    step();
    chk("starve_hold", {31'd0, pipe_hold}, 1);
    chk("starve_paddr", {27'd0, rf_waddr}, 2);
    pipe(0, 0, 0); step();
    chk("starve_faddr", {27'd0, rf_waddr}, 13);
    chk("starve_fwe", {31'd0, rf_we}, 1);
    chk("starve_unhold", {31'd0, pipe_hold}, 0);

    // Set/clear race on r4
    lu_issue = 1; lu_issue_addr = 4; step();
    lu_issue = 0; rd_addr = 4; #1;
    chk("race_haz0", {31'd0, hazard}, 1);
    lu(1, 4, 32'h44); step();
    lu(0, 0, 0); lu_issue = 1; lu_issue_addr = 4; step();
    lu_issue = 0; #1;
    chk("race_addr", {27'd0, rf_waddr}, 4);
    chk("race_haz1", {31'd0, hazard}, 1);
    lu(1, 4, 32'h45); step();
    lu(0, 0, 0); step();
    chk("race_haz_clr", {31'd0, hazard}, 0);
    rd_addr = 0;

    // Async reset with two FIFO entries and three pending bits
    lu_issue = 1; lu_issue_addr = 20; step();
    lu_issue_addr = 21; step();
    lu_issue_addr = 22; step();
    lu_issue = 0;
    pipe(1, 3, 32'hCAFE); lu(1, 20, 32'h200); step();
    lu(1, 21, 32'h210); step();
    pipe(0, 0, 0); lu(0, 0, 0);
    rs_addr = 20; rt_addr = 21; rd_addr = 22; #1;
    chk("pre_ready", {31'd0, lu_ready}, 0);
    chk("pre_haz", {31'd0, hazard}, 1);
    chk("pre_addr", {27'd0, rf_waddr}, 3);
    #1 rst = 1'b1; #1;
    chk("arst_we", {31'd0, rf_we}, 0);
    chk("arst_addr", {27'd0, rf_waddr}, 0);
    chk("arst_data", rf_wdata, 0);
    chk("arst_hold", {31'd0, pipe_hold}, 0);
    chk("arst_ready", {31'd0, lu_ready}, 1);
    chk("arst_haz", {31'd0, hazard}, 0);
    step();
    rst = 1'b0; step();
    chk("post_rst_we", {31'd0, rf_we}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
